// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX feeder: FSM state encoding and the default byte width.
package uart_pkg;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, only pointers and count.
module uart_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// Drains a host-side FIFO into the UART transmitter one byte at a time, pacing on its busy flag.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 15,
  localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  tx_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  timeout_err,
  output logic [7:0]            lost_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA_IN_TX,
  output logic                  DATA_VALID_TX,
  input  logic                  busy_flag_TX,
  input  logic                  data_lost_TX
);
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e             state;
  logic [TW-1:0]         timer;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  assign pop = (state == IDLE) && !empty && !busy_flag_TX;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (tx_clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge tx_clk) begin
    if (!rst) begin
      state         <= IDLE;
      timer         <= '0;
      P_DATA_IN_TX  <= '0;
      DATA_VALID_TX <= 1'b0;
      overflow      <= 1'b0;
      timeout_err   <= 1'b0;
      lost_cnt      <= '0;
    end else begin
      DATA_VALID_TX <= 1'b0;
      if (wr_en && full) overflow <= 1'b1;
      if (data_lost_TX && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;

      // The launch pulse is registered on the pop edge so it is high during ISSUE.
      case (state)
        IDLE: begin
          if (pop) begin
            P_DATA_IN_TX  <= head;
            DATA_VALID_TX <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy_flag_TX) begin
            state <= WAIT_DONE;
          end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!busy_flag_TX) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple busy-flag responder in the step task.
module tb_uart_tx_feeder;
  logic       tx_clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, empty, overflow, timeout_err, DATA_VALID_TX;
  logic [4:0] count;
  logic [7:0] lost_cnt, P_DATA_IN_TX;
  logic       busy_flag_TX = 1'b0;
  logic       data_lost_TX = 1'b0;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  logic [7:0]  got[$];
  int unsigned got_cyc[$];
  bit          prev_dv = 1'b0;
  bit          auto_busy = 1'b0;
  bit          pend = 1'b0;
  int unsigned hold = 0;

  uart_tx_feeder #(
    .DATA_WIDTH   (8),
    .DEPTH        (16),
    .BUSY_TIMEOUT (15)
  ) dut (
    .tx_clk        (tx_clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .timeout_err   (timeout_err),
    .lost_cnt      (lost_cnt),
    .P_DATA_IN_TX  (P_DATA_IN_TX),
    .DATA_VALID_TX (DATA_VALID_TX),
    .busy_flag_TX  (busy_flag_TX),
    .data_lost_TX  (data_lost_TX)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, then run the busy responder.
  task automatic step();
    @(posedge tx_clk);
    #1;
    cyc++;
    if (DATA_VALID_TX === 1'b1) begin
      check("dv_not_back_to_back", {31'd0, prev_dv}, 32'd0);
      got.push_back(P_DATA_IN_TX);
      got_cyc.push_back(cyc);
      if (auto_busy) check("dv_only_when_idle_tx", {31'd0, busy_flag_TX}, 32'd0);
    end
    prev_dv = (DATA_VALID_TX === 1'b1);
    if (auto_busy) begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) busy_flag_TX = 1'b0;
      end
      if (pend) begin
        busy_flag_TX = 1'b1;
        hold = 40;
        pend = 1'b0;
      end
      if (DATA_VALID_TX === 1'b1) pend = 1'b1;
    end
  endtask

  task automatic write(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_pulses(input int unsigned n, input int unsigned bound);
    for (int unsigned i = 0; i < bound && got.size() < n; i++) step();
    check("pulse_count_reached", got.size(), n);
  endtask

  task automatic wait_idle();
    for (int unsigned i = 0; i < 200 && (hold != 0 || pend || busy_flag_TX); i++) step();
    check("responder_idle", {31'd0, (hold == 0 && !pend && !busy_flag_TX)}, 32'd1);
    repeat (3) step();
  endtask

  initial begin
    int unsigned n0;
    int unsigned err_cyc;

    // Reset state
    repeat (3) step();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_dv", DATA_VALID_TX, 0);
    check("rst_pdata", P_DATA_IN_TX, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_lost", lost_cnt, 0);
    rst = 1'b1;
    step();

    // 1: single byte latency
    auto_busy = 1'b1;
    write(8'hA5);
    check("t1_dv_low_first", DATA_VALID_TX, 0);
    check("t1_count_one", count, 1);
    step();
    check("t1_dv_high", DATA_VALID_TX, 1);
    check("t1_data", P_DATA_IN_TX, 8'hA5);
    check("t1_count_zero", count, 0);
    step();
    check("t1_dv_single", DATA_VALID_TX, 0);
    check("t1_data_held", P_DATA_IN_TX, 8'hA5);
    wait_idle();

    // 2: burst of four, paced on busy
    n0 = got.size();
    for (int unsigned i = 1; i <= 4; i++) write(8'(i));
    wait_pulses(n0 + 4, 400);
    for (int unsigned i = 0; i < 4; i++)
      if (n0 + i < got.size()) check("t2_order", got[n0 + i], i + 1);
    wait_idle();

    // 3: overflow with transmitter busy
    auto_busy = 1'b0;
    busy_flag_TX = 1'b1;
    n0 = got.size();
    for (int unsigned i = 0; i < 16; i++) write(8'(8'h10 + i));
    check("t3_full", full, 1);
    check("t3_count16", count, 16);
    check("t3_no_ovf_yet", overflow, 0);
    write(8'hEE);
    write(8'hEF);
    check("t3_overflow", overflow, 1);
    check("t3_count_still16", count, 16);
    check("t3_no_pulse", got.size(), n0);
    busy_flag_TX = 1'b0;
    hold = 0;
    pend = 1'b0;
    auto_busy = 1'b1;
    wait_pulses(n0 + 16, 2000);
    for (int unsigned i = 0; i < 16; i++)
      if (n0 + i < got.size()) check("t3_order", got[n0 + i], 8'h10 + i);
    wait_idle();
    check("t3_empty_after", empty, 1);

    // 4: busy never rises -> timeout, next byte still sent
    auto_busy = 1'b0;
    busy_flag_TX = 1'b0;
    n0 = got.size();
    write(8'h55);
    write(8'h66);
    check("t4_first_pulse", got.size(), n0 + 1);
    err_cyc = 0;
    for (int unsigned i = 0; i < 40 && timeout_err !== 1'b1; i++) step();
    check("t4_timeout_err", timeout_err, 1);
    err_cyc = cyc;
    hold = 0;
    pend = 1'b0;
    auto_busy = 1'b1;
    if (got.size() > n0) begin
      check("t4_first_data", got[n0], 8'h55);
      check("t4_timeout_delay_ok",
            {31'd0, (err_cyc - got_cyc[n0] == 15 || err_cyc - got_cyc[n0] == 16)}, 32'd1);
    end
    wait_pulses(n0 + 2, 10);
    if (got.size() > n0 + 1) check("t4_next_byte", got[n0 + 1], 8'h66);
    wait_idle();

    // 5: reset during WAIT_DONE flushes the queue
    auto_busy = 1'b0;
    busy_flag_TX = 1'b0;
    n0 = got.size();
    for (int unsigned i = 0; i < 4; i++) write(8'(8'h71 + i));
    busy_flag_TX = 1'b1;
    repeat (3) step();
    check("t5_one_popped", got.size(), n0 + 1);
    check("t5_count3", count, 3);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("t5_empty", empty, 1);
    check("t5_count0", count, 0);
    check("t5_dv0", DATA_VALID_TX, 0);
    check("t5_pdata0", P_DATA_IN_TX, 0);
    check("t5_timeout_cleared", timeout_err, 0);
    check("t5_overflow_cleared", overflow, 0);
    busy_flag_TX = 1'b0;
    repeat (10) step();
    check("t5_no_pulse", got.size(), n0 + 1);
    auto_busy = 1'b1;
    write(8'h99);
    step();
    check("t5_new_pulse", got.size(), n0 + 2);
    if (got.size() > n0 + 1) check("t5_new_data", got[n0 + 1], 8'h99);
    wait_idle();

    // 6: saturating lost counter, then simultaneous push/pop
    data_lost_TX = 1'b1;
    repeat (10) step();
    check("t6_lost10", lost_cnt, 10);
    repeat (290) step();
    data_lost_TX = 1'b0;
    step();
    check("t6_lost_sat", lost_cnt, 255);
    auto_busy = 1'b0;
    busy_flag_TX = 1'b1;
    for (int unsigned i = 0; i < 5; i++) write(8'(8'hC0 + i));
    check("t6_count5", count, 5);
    busy_flag_TX = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'hCF;
    step();
    wr_en = 1'b0;
    busy_flag_TX = 1'b1;
    check("t6_pushpop_count", count, 5);
    check("t6_pushpop_data", P_DATA_IN_TX, 8'hC0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end
endmodule
